// File: rtl/plane_hit_detector.sv
// plane_hit_detector
// Turns raw per-pixel overlap between the plane and the hazard objects into at
// most one collision pulse per frame, then holds a whole-frame invulnerability
// window during which the plane blinks. Falls permanently silent once the lives
// counter reports no_life, until reset.
//
// Ports
//   clk                  in  system clock
//   resetN               in  asynchronous active-low reset
//   startOfFrame         in  1-cycle pulse at the first pixel of each frame
//   planeDrawingRequest  in  plane pixel opaque at the current pixel
//   hazardDrawingRequest in  per-hazard opaque flags at the current pixel
//   no_life              in  lives exhausted, from the lives counter
//   collision            out 1-cycle hit pulse to the lives counter
//   hit_hazard_id        out index of the hazard behind the last pulse
//   invulnerable         out high while in the grace window
//   plane_visible        out renderer enable for the plane (blinks in grace)
module plane_hit_detector #(
  parameter int unsigned NUM_HAZARDS  = 4,
  parameter int unsigned GRACE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           planeDrawingRequest,
  input  logic [NUM_HAZARDS-1:0]         hazardDrawingRequest,
  input  logic                           no_life,
  output logic                           collision,
  output logic [$clog2(NUM_HAZARDS)-1:0] hit_hazard_id,
  output logic                           invulnerable,
  output logic                           plane_visible
);

  localparam int unsigned ID_W = $clog2(NUM_HAZARDS);
  localparam int unsigned GC_W = $clog2(GRACE_FRAMES + 1);
  localparam int unsigned BC_W = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {ARMED, GRACE, DEAD} state_t;

  state_t            r_state,      w_state_nxt;
  logic              r_collision,  w_collision_nxt;
  logic [ID_W-1:0]   r_hit_id,     w_hit_id_nxt;
  logic              r_invuln,     w_invuln_nxt;
  logic              r_visible,    w_visible_nxt;
  logic [GC_W-1:0]   r_grace_cnt,  w_grace_cnt_nxt;
  logic [BC_W-1:0]   r_blink_cnt,  w_blink_cnt_nxt;
  logic              r_frame_hit,  w_frame_hit_nxt;
  logic [ID_W-1:0]   r_frame_id,   w_frame_id_nxt;

  logic              w_ov;
  logic [ID_W-1:0]   w_win;

  assign w_ov = planeDrawingRequest & (|hazardDrawingRequest);

  // Lowest set hazard index wins: scan downwards so the lowest index is written last.
  always_comb begin
    w_win = '0;
    for (int i = NUM_HAZARDS - 1; i >= 0; i--) begin
      if (hazardDrawingRequest[i]) w_win = ID_W'(i);
    end
  end

  // Next-state, next-output and frame accumulation.
  always_comb begin
    w_state_nxt     = r_state;
    w_collision_nxt = 1'b0;
    w_hit_id_nxt    = r_hit_id;
    w_invuln_nxt    = r_invuln;
    w_visible_nxt   = r_visible;
    w_grace_cnt_nxt = r_grace_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_frame_hit_nxt = r_frame_hit;
    w_frame_id_nxt  = r_frame_id;

    // Overlap on the SOF cycle starts the new frame's accumulation.
    if (startOfFrame) begin
      w_frame_hit_nxt = w_ov;
      if (w_ov) w_frame_id_nxt = w_win;
    end else if (w_ov && !r_frame_hit) begin
      w_frame_hit_nxt = 1'b1;
      w_frame_id_nxt  = w_win;
    end

    // no_life overrides everything, including a hit pending on this SOF.
    if (no_life || r_state == DEAD) begin
      w_state_nxt   = DEAD;
      w_invuln_nxt  = 1'b0;
      w_visible_nxt = 1'b1;
    end else if (startOfFrame) begin
      case (r_state)
        ARMED: begin
          if (r_frame_hit) begin
            w_state_nxt     = GRACE;
            w_collision_nxt = 1'b1;
            w_hit_id_nxt    = r_frame_id;
            w_grace_cnt_nxt = GC_W'(GRACE_FRAMES - 1);
            w_blink_cnt_nxt = '0;
            w_visible_nxt   = 1'b0;
            w_invuln_nxt    = 1'b1;
          end
        end
        GRACE: begin
          if (r_grace_cnt == '0) begin
            w_state_nxt   = ARMED;
            w_visible_nxt = 1'b1;
            w_invuln_nxt  = 1'b0;
          end else begin
            w_grace_cnt_nxt = r_grace_cnt - GC_W'(1);
            if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
              w_blink_cnt_nxt = '0;
              w_visible_nxt   = ~r_visible;
            end else begin
              w_blink_cnt_nxt = r_blink_cnt + BC_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = DEAD;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ARMED;
      r_collision <= 1'b0;
      r_hit_id    <= '0;
      r_invuln    <= 1'b0;
      r_visible   <= 1'b1;
      r_grace_cnt <= '0;
      r_blink_cnt <= '0;
      r_frame_hit <= 1'b0;
      r_frame_id  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_collision <= w_collision_nxt;
      r_hit_id    <= w_hit_id_nxt;
      r_invuln    <= w_invuln_nxt;
      r_visible   <= w_visible_nxt;
      r_grace_cnt <= w_grace_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_frame_hit <= w_frame_hit_nxt;
      r_frame_id  <= w_frame_id_nxt;
    end
  end

  assign collision     = r_collision;
  assign hit_hazard_id = r_hit_id;
  assign invulnerable  = r_invuln;
  assign plane_visible = r_visible;

endmodule
